uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver with 16x oversampling; the receive counterpart of the team's UART transmitter.
- Samples the asynchronous rx line using the shared baud-rate generator tick (s_tick).
- Rejects start-bit glitches, majority-votes each bit, and checks the stop bit.
- Delivers each word with a one-cycle done pulse to the RX FIFO write port.

Parameters:
- DBITS, 8, data bits per frame, LSB first; legal range 5..8.
- SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- ckht  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- s_tick  input  1  oversample tick, 16 per bit period; one ckht cycle wide.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  DBITS  last received word; held until the next completion.
- rx_done_tick  output  1  one-cycle pulse when a frame completes; drives the FIFO write strobe.
- frame_err  output  1  stop-bit sample was 0 for the word in rx_data; valid from the same cycle as rx_done_tick and held with rx_data.

Behaviour:
- Reset values:
  - Outputs: rx_data = 0, rx_done_tick = 0, frame_err = 0.
  - Internal: state = idle, s = 0, n = 0, shift register = 0, both synchronizer flops = 1.
  - Reset is asserted asynchronously at any time. A frame in progress is discarded with no done pulse.
- Input synchronizer:
  - rx passes through 2 ckht flops to form rx_s. All decisions use rx_s only.
  - Latency from an rx edge to rx_s is 2 ckht cycles.
- Counters:
  - s is 4 bits and wraps only under FSM control.
  - n is 3 bits.
  - All counter updates happen only in cycles where s_tick = 1, except the idle-to-start transition.
- FSM states: idle, start, data, stop.
  - idle:
    - When rx_s = 0, go to start with s = 0. This transition does not require s_tick.
  - start:
    - On each s_tick: if s = 7 (mid start bit), check rx_s.
    - If rx_s = 0: go to data with s = 0, n = 0.
    - If rx_s = 1 (glitch): go to idle. No output change.
    - Otherwise s = s + 1.
  - data:
    - On s_tick with s = 13, store vote bit v0 = rx_s.
    - On s_tick with s = 14, store vote bit v1 = rx_s.
    - On s_tick with s = 15:
      - bit = majority(v0, v1, rx_s).
      - Shift register = {bit, sr[DBITS-1:1]}, so the first received bit ends in bit 0.
      - s = 0.
      - If n = DBITS-1, go to stop; else n = n + 1.
    - Otherwise on s_tick, s = s + 1.
  - stop:
    - Sampling is the same 3-vote majority, taken at s = SB_TICK-3, SB_TICK-2 and SB_TICK-1.
    - On s_tick with s = SB_TICK-1, in the next cycle:
      - rx_data = shift register.
      - frame_err = NOT(majority).
      - rx_done_tick = 1 for exactly one ckht cycle.
      - state = idle.
    - s must count to SB_TICK-1, so s is widened to clog2(SB_TICK) bits when SB_TICK > 16.
- Frame errors: a frame with frame_err = 1 is still delivered, with a done pulse and data. The consumer decides whether to discard it.
- Start after stop: the FSM returns to idle at mid stop bit. A falling edge of the next start bit is detected immediately, which supports back-to-back frames.
- rx stuck low (break): after a frame_err completion, idle sees rx_s = 0 and starts a new frame. Each 10-bit window reports data 0x00 with frame_err = 1.
- Outputs are registered. rx_done_tick is never high for more than 1 cycle per frame.

Test Plan:
- Bench setup: s_tick every 4 ckht cycles, so 1 bit = 64 cycles.
- Reset mid-frame: assert rst during data bit 3 of 0x5A → outputs 0, state idle. After release, a clean 0x5A frame → rx_data = 0x5A with one done pulse.
- Nominal frame: 0xA5 sent LSB first with 1 stop bit → rx_done_tick = 1 for 1 cycle. This occurs about 9.5 bit periods + 2 cycles after the start edge. Checks: rx_data = 0xA5, frame_err = 0.
- Start glitch: rx low for 5 bit-ticks (20 cycles), then high → no done pulse, FSM back in idle. A following frame 0x3C is received correctly.
- Noise in data bit: frame 0xFF with rx forced to 0 for 1 s_tick at s = 14 of bit 2 → rx_data = 0xFF (majority vote wins).
- Framing error: frame 0x81 with stop bit driven 0 → rx_data = 0x81, frame_err = 1. The next clean frame 0x7E clears frame_err to 0.
- Back-to-back frames: 0x00, 0xFF, 0x55 with no idle gap → three done pulses, each about 10 bit periods apart, with correct data and no frame_err.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Bundle between the line/tick source and the UART receiver.
// rx_done_tick is a one-cycle valid strobe qualifying rx_data/frame_err; there is no ready (no backpressure).
interface uart_receiver_if #(
    parameter int DBITS = 8
);
    logic             s_tick;
    logic             rx;
    logic [DBITS-1:0] rx_data;
    logic             rx_done_tick;
    logic             frame_err;
    logic [1:0]       dbg_state;

    modport master (
        output s_tick, rx,
        input  rx_data, rx_done_tick, frame_err, dbg_state
    );

    modport slave (
        input  s_tick, rx,
        output rx_data, rx_done_tick, frame_err, dbg_state
    );
endinterface

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver: start-glitch rejection, 3-sample majority per bit,
// stop-bit check, registered word with a one-cycle done pulse.
module uart_receiver #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input  logic           ckht,
    input  logic           rst,
    uart_receiver_if.slave rx_if
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [SW-1:0]    r_s, w_s_nxt;
    logic [2:0]       r_n, w_n_nxt;
    logic [DBITS-1:0] r_sr, w_sr_nxt;
    logic             r_v0, w_v0_nxt;
    logic             r_v1, w_v1_nxt;
    logic [DBITS-1:0] r_data, w_data_nxt;
    logic             r_done, w_done_nxt;
    logic             r_ferr, w_ferr_nxt;
    logic             r_rx_meta, r_rx_s;
    logic             w_maj;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge ckht or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_if.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_maj = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);

    always_ff @(posedge ckht or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_sr    <= '0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_sr    <= w_sr_nxt;
            r_v0    <= w_v0_nxt;
            r_v1    <= w_v1_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_sr_nxt    = r_sr;
        w_v0_nxt    = r_v0;
        w_v1_nxt    = r_v1;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = r_ferr;
        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = START;
                    w_s_nxt     = '0;
                end
            end
            START: begin
                if (rx_if.s_tick) begin
                    if (r_s == SW'(7)) begin
                        if (!r_rx_s) begin
                            w_state_nxt = DATA;
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (rx_if.s_tick) begin
                    if (r_s == SW'(13)) w_v0_nxt = r_rx_s;
                    if (r_s == SW'(14)) w_v1_nxt = r_rx_s;
                    if (r_s == SW'(15)) begin
                        w_sr_nxt = {w_maj, r_sr[DBITS-1:1]};
                        w_s_nxt  = '0;
                        if (r_n == 3'(DBITS - 1)) w_state_nxt = STOP;
                        else                      w_n_nxt     = r_n + 3'd1;
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (rx_if.s_tick) begin
                    if (r_s == SW'(SB_TICK - 3)) w_v0_nxt = r_rx_s;
                    if (r_s == SW'(SB_TICK - 2)) w_v1_nxt = r_rx_s;
                    // Leave at mid stop bit so the next start edge can follow without a gap.
                    if (r_s == SW'(SB_TICK - 1)) begin
                        w_data_nxt  = r_sr;
                        w_ferr_nxt  = ~w_maj;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                        w_s_nxt     = '0;
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign rx_if.rx_data      = r_data;
    assign rx_if.rx_done_tick = r_done;
    assign rx_if.frame_err    = r_ferr;
    assign rx_if.dbg_state    = r_state;
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: s_tick every 4 cycles (64 cycles per bit), frames driven on rx,
// completions captured by a monitor and checked against an expected queue.
module tb_uart_receiver;
    localparam int DBITS   = 8;
    localparam int BIT_CYC = 64;

    logic ckht = 1'b0;
    logic rst  = 1'b1;

    uart_receiver_if #(.DBITS(DBITS)) bus ();

    uart_receiver #(.DBITS(DBITS), .SB_TICK(16)) dut (
        .ckht  (ckht),
        .rst   (rst),
        .rx_if (bus)
    );

    always #5 ckht = ~ckht;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tick_ph  = 0;
    int start_cyc = 0;
    int done_long = 0;
    logic prev_done = 1'b0;

    logic [DBITS:0] exp_q[$];
    logic [DBITS:0] got_q[$];
    int             got_t[$];

    always @(posedge ckht) cyc <= cyc + 1;

    initial begin
        bus.s_tick = 1'b0;
        forever begin
            @(negedge ckht);
            tick_ph = (tick_ph + 1) % 4;
            bus.s_tick = (tick_ph == 0);
        end
    end

    // Monitor: capture every completion with its cycle stamp; flag any pulse longer than one cycle.
    always @(negedge ckht) begin
        if (bus.rx_done_tick) begin
            got_q.push_back({bus.frame_err, bus.rx_data});
            got_t.push_back(cyc);
            if (prev_done) done_long <= done_long + 1;
        end
        prev_done <= bus.rx_done_tick;
    end

    task automatic idle_bits(input int n);
        bus.rx = 1'b1;
        repeat (n * BIT_CYC) @(negedge ckht);
    endtask

    // stop_lo_cyc > 0 drives the stop bit low for that many cycles; glitch_bit >= 0 pulls
    // that data bit low for one tick period near its middle.
    task automatic send_frame(input logic [DBITS-1:0] d, input int stop_lo_cyc, input int glitch_bit);
        bus.rx = 1'b0;
        start_cyc = cyc;
        repeat (BIT_CYC) @(negedge ckht);
        for (int i = 0; i < DBITS; i++) begin
            bus.rx = d[i];
            if (i == glitch_bit) begin
                repeat (24) @(negedge ckht);
                bus.rx = 1'b0;
                repeat (4) @(negedge ckht);
                bus.rx = d[i];
                repeat (BIT_CYC - 28) @(negedge ckht);
            end else begin
                repeat (BIT_CYC) @(negedge ckht);
            end
        end
        bus.rx = 1'b0;
        repeat (stop_lo_cyc) @(negedge ckht);
        bus.rx = 1'b1;
        repeat (BIT_CYC - stop_lo_cyc) @(negedge ckht);
    endtask

    task automatic flush_queues();
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic test_reset();
        bus.rx = 1'b1;
        repeat (3) @(negedge ckht);
        rst = 1'b0;
        repeat (4) @(negedge ckht);
        checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
        checks++; if (bus.rx_done_tick !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.rx_done_tick); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
        checks++; if (bus.dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.dbg_state); end
    endtask

    task automatic test_nominal();
        logic [DBITS:0] g, e;
        int lat;
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 0, -1);
        idle_bits(1);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL nominal_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); lat = got_t.pop_front() - start_cyc;
            checks++; if (g[7:0] !== e[7:0]) begin failures++; $display("FAIL nominal_data got=%h exp=%h", g[7:0], e[7:0]); end
            checks++; if (g[8] !== e[8]) begin failures++; $display("FAIL nominal_frame_err got=%b exp=%b", g[8], e[8]); end
            checks++; if (lat < 600 || lat > 620) begin failures++; $display("FAIL nominal_latency got=%0d exp=600..620", lat); end
        end
        flush_queues();
    endtask

    task automatic test_reset_mid_frame();
        logic [DBITS-1:0] d = 8'h5A;
        logic [DBITS:0] g, e;
        bus.rx = 1'b0;
        repeat (BIT_CYC) @(negedge ckht);
        for (int i = 0; i < 3; i++) begin
            bus.rx = d[i];
            repeat (BIT_CYC) @(negedge ckht);
        end
        bus.rx = d[3];
        repeat (BIT_CYC / 2) @(negedge ckht);
        checks++; if (bus.dbg_state !== 2'd2) begin failures++; $display("FAIL midframe_in_data got=%0d exp=2", bus.dbg_state); end
        rst = 1'b1;
        bus.rx = 1'b1;
        #1;
        checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL midframe_rst_data got=%h exp=00", bus.rx_data); end
        checks++; if (bus.dbg_state !== 2'd0) begin failures++; $display("FAIL midframe_rst_state got=%0d exp=0", bus.dbg_state); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL midframe_rst_ferr got=%b exp=0", bus.frame_err); end
        repeat (3) @(negedge ckht);
        rst = 1'b0;
        idle_bits(2);
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL midframe_no_done got=%0d exp=0", got_q.size()); end
        flush_queues();
        exp_q.push_back({1'b0, 8'h5A});
        send_frame(8'h5A, 0, -1);
        idle_bits(1);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL midframe_after_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL midframe_after_word got=%h exp=%h", g, e); end
        end
        flush_queues();
    endtask

    task automatic test_start_glitch();
        logic [DBITS:0] g, e;
        bus.rx = 1'b0;
        repeat (12) @(negedge ckht);
        checks++; if (bus.dbg_state !== 2'd1) begin failures++; $display("FAIL glitch_in_start got=%0d exp=1", bus.dbg_state); end
        repeat (8) @(negedge ckht);
        idle_bits(2);
        checks++; if (bus.dbg_state !== 2'd0) begin failures++; $display("FAIL glitch_back_idle got=%0d exp=0", bus.dbg_state); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL glitch_no_done got=%0d exp=0", got_q.size()); end
        flush_queues();
        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 0, -1);
        idle_bits(1);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL glitch_after_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL glitch_after_word got=%h exp=%h", g, e); end
        end
        flush_queues();
    endtask

    task automatic test_noise();
        logic [DBITS:0] g, e;
        exp_q.push_back({1'b0, 8'hFF});
        send_frame(8'hFF, 0, 2);
        idle_bits(1);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL noise_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL noise_word got=%h exp=%h", g, e); end
        end
        flush_queues();
    endtask

    task automatic test_frame_err();
        logic [DBITS:0] g, e;
        exp_q.push_back({1'b1, 8'h81});
        // Stop bit held low across all three vote samples, released before the bit ends.
        send_frame(8'h81, 40, -1);
        idle_bits(2);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL ferr_word got=%h exp=%h", g, e); end
        end
        checks++; if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL ferr_held got=%b exp=1", bus.frame_err); end
        checks++; if (bus.rx_data !== 8'h81) begin failures++; $display("FAIL ferr_data_held got=%h exp=81", bus.rx_data); end
        flush_queues();
        exp_q.push_back({1'b0, 8'h7E});
        send_frame(8'h7E, 0, -1);
        idle_bits(1);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL ferr_clear_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL ferr_clear_word got=%h exp=%h", g, e); end
        end
        flush_queues();
    endtask

    task automatic test_back_to_back();
        logic [DBITS-1:0] words[3];
        logic [DBITS:0] g, e;
        int t_prev, t_cur;
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h55;
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, words[k]});
        for (int k = 0; k < 3; k++) send_frame(words[k], 0, -1);
        idle_bits(1);
        checks++; if (got_q.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got_q.size()); end
        t_prev = 0;
        for (int k = 0; k < 3 && got_q.size() > 0; k++) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); t_cur = got_t.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", k, g, e); end
            if (k > 0) begin
                checks++;
                if (t_cur - t_prev < 630 || t_cur - t_prev > 650) begin
                    failures++; $display("FAIL b2b_spacing%0d got=%0d exp=630..650", k, t_cur - t_prev);
                end
            end
            t_prev = t_cur;
        end
        checks++; if (done_long != 0) begin failures++; $display("FAIL done_width got=%0d exp=0", done_long); end
        flush_queues();
    endtask

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_nominal();
        test_reset_mid_frame();
        test_start_glitch();
        test_noise();
        test_frame_err();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
